config_bit_loader: RTL

// - Writer side of the fabric configuration-bit interface: it produces the C_bit vector that

---
 rtl/config_bit_loader.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/config_bit_loader.sv
// -----------------------------------------------------------------------------
// config_bit_loader
// Writer side of the fabric configuration-bit interface. A framed serial
// stream (8-bit sync word, WIDTH data bits MSB-first, one even-parity bit) is
// received and its payload is committed to C_bit only when the frame is valid.
//
// Ports
//   CLK       in   1      clock, rising edge
//   resetn    in   1      synchronous reset, active-low
//   s_data    in   1      serial configuration bit
//   s_valid   in   1      s_data is valid this cycle
//   s_ready   out  1      bit accepted when s_valid && s_ready
//   C_bit     out  WIDTH  committed configuration bits (direct flop outputs)
//   cfg_done  out  1      1-cycle pulse: frame committed to C_bit
//   cfg_err   out  1      1-cycle pulse: parity fail or timeout, frame dropped
//   busy      out  1      high whenever the loader is not hunting for sync
// -----------------------------------------------------------------------------
module config_bit_loader #(
  parameter int unsigned      WIDTH   = 12,
  parameter logic [WIDTH-1:0] INIT    = {WIDTH{1'b0}},
  parameter logic [7:0]       SYNC    = 8'hA5,
  parameter int unsigned      TIMEOUT = 255
) (
  input  logic             CLK,
  input  logic             resetn,
  input  logic             s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] C_bit,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic             busy
);

  localparam int unsigned BCW = $clog2(WIDTH + 1);
  localparam int unsigned TCW = $clog2(TIMEOUT + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);
  localparam logic [TCW-1:0] TO_LAST  = TCW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    DATA   = 2'd1,
    PAR    = 2'd2,
    COMMIT = 2'd3
  } state_e;

  // True when payload plus parity bit hold an even number of ones.
  function automatic logic even_parity_ok(input logic [WIDTH-1:0] d, input logic p);
    return ~(^d ^ p);
  endfunction

  state_e           state_q, state_d;
  // Only the 7 most recent bits are stored; the 8th is the incoming s_data.
  logic [6:0]       sync_sr_q, sync_sr_d;
  logic [WIDTH-1:0] data_sr_q, data_sr_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [TCW-1:0]   to_cnt_q, to_cnt_d;
  logic [WIDTH-1:0] c_bit_q, c_bit_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             accept_s;
  logic [WIDTH:0]   shift_s;

  assign accept_s = s_valid && ready_q;
  assign shift_s  = {data_sr_q, s_data};

  // Next-state logic for the frame receiver.
  always_comb begin
    state_d   = state_q;
    sync_sr_d = sync_sr_q;
    data_sr_d = data_sr_q;
    bit_cnt_d = bit_cnt_q;
    to_cnt_d  = to_cnt_q;
    c_bit_d   = c_bit_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      HUNT: begin
        to_cnt_d = {TCW{1'b0}};
        if (accept_s) begin
          if ({sync_sr_q, s_data} == SYNC) begin
            state_d   = DATA;
            sync_sr_d = 7'd0;
            data_sr_d = {WIDTH{1'b0}};
            bit_cnt_d = {BCW{1'b0}};
          end else begin
            sync_sr_d = {sync_sr_q[5:0], s_data};
          end
        end else begin
          sync_sr_d = sync_sr_q;
        end
      end
      DATA: begin
        if (accept_s) begin
          data_sr_d = shift_s[WIDTH-1:0];
          bit_cnt_d = bit_cnt_q + {{(BCW-1){1'b0}}, 1'b1};
          to_cnt_d  = {TCW{1'b0}};
          if (bit_cnt_q == LAST_BIT) begin
            state_d = PAR;
          end else begin
            state_d = DATA;
          end
        end else if (to_cnt_q == TO_LAST) begin
          // Idle limit reached with no accept this cycle: drop the frame.
          state_d   = HUNT;
          sync_sr_d = 7'd0;
          to_cnt_d  = {TCW{1'b0}};
          err_d     = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + {{(TCW-1){1'b0}}, 1'b1};
        end
      end
      PAR: begin
        if (accept_s) begin
          to_cnt_d = {TCW{1'b0}};
          if (even_parity_ok(data_sr_q, s_data)) begin
            state_d = COMMIT;
            c_bit_d = data_sr_q;
            done_d  = 1'b1;
          end else begin
            state_d   = HUNT;
            sync_sr_d = 7'd0;
            err_d     = 1'b1;
          end
        end else if (to_cnt_q == TO_LAST) begin
          state_d   = HUNT;
          sync_sr_d = 7'd0;
          to_cnt_d  = {TCW{1'b0}};
          err_d     = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + {{(TCW-1){1'b0}}, 1'b1};
        end
      end
      COMMIT: begin
        state_d   = HUNT;
        sync_sr_d = 7'd0;
        to_cnt_d  = {TCW{1'b0}};
      end
      default: begin
        state_d   = HUNT;
        sync_sr_d = 7'd0;
        to_cnt_d  = {TCW{1'b0}};
      end
    endcase
    // Handshake and status are registered from the next state so they are
    // clean flop outputs in the cycle the state takes effect.
    ready_d = (state_d != COMMIT);
    busy_d  = (state_d != HUNT);
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state_q   <= HUNT;
      sync_sr_q <= 7'd0;
      data_sr_q <= {WIDTH{1'b0}};
      bit_cnt_q <= {BCW{1'b0}};
      to_cnt_q  <= {TCW{1'b0}};
      c_bit_q   <= INIT;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_sr_q <= sync_sr_d;
      data_sr_q <= data_sr_d;
      bit_cnt_q <= bit_cnt_d;
      to_cnt_q  <= to_cnt_d;
      c_bit_q   <= c_bit_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign s_ready  = ready_q;
  assign C_bit    = c_bit_q;
  assign cfg_done = done_q;
  assign cfg_err  = err_q;
  assign busy     = busy_q;

endmodule
